// File: rtl/quad_step_decoder.sv
// Quadrature (a,b) front-end: synchronise, glitch-filter and decode into step/dir
// pulses for an up/down counter, flagging double-bit transitions as errors.
module quad_step_decoder #(
  parameter int unsigned FILT = 3,
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a,
  input  logic            b,
  input  logic            en,
  output logic            step,
  output logic            dir,
  output logic            err,
  output logic [ERRW-1:0] err_cnt,
  output logic [1:0]      ab_q
);

  localparam int unsigned CW = 4;
  localparam int unsigned IW = 5;
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(FILT + 2);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [1:0]          s1, s2;
  logic [1:0]          filt, filt_nxt;
  logic [1:0]          prev, prev_nxt;
  logic [1:0][CW-1:0]  fcnt, fcnt_nxt;
  logic [IW-1:0]       init_cnt, init_nxt;
  logic                step_nxt, err_nxt, dir_nxt;
  logic [ERRW-1:0]     err_cnt_nxt;

  // Two-flop synchroniser, bit 1 = a, bit 0 = b
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {a, b};
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      filt     <= 2'b00;
      prev     <= 2'b00;
      fcnt     <= '0;
      step     <= 1'b0;
      err      <= 1'b0;
      dir      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_nxt;
      filt     <= filt_nxt;
      prev     <= prev_nxt;
      fcnt     <= fcnt_nxt;
      step     <= step_nxt;
      err      <= err_nxt;
      dir      <= dir_nxt;
      err_cnt  <= err_cnt_nxt;
    end
  end

  // Next-state: INIT seeds filter/prev from the synchroniser, RUN filters and decodes
  always_comb begin
    state_nxt   = state;
    init_nxt    = init_cnt;
    filt_nxt    = filt;
    prev_nxt    = filt;
    fcnt_nxt    = fcnt;
    step_nxt    = 1'b0;
    err_nxt     = 1'b0;
    dir_nxt     = dir;
    err_cnt_nxt = err_cnt;

    case (state)
      ST_INIT: begin
        filt_nxt = s2;
        prev_nxt = s2;
        fcnt_nxt = '0;
        if (init_cnt == INIT_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          init_nxt = init_cnt + IW'(1);
        end
      end
      ST_RUN: begin
        for (int i = 0; i < 2; i++) begin
          if (s2[i] != filt[i]) begin
            if (fcnt[i] == FILT_LAST) begin
              filt_nxt[i] = s2[i];
              fcnt_nxt[i] = '0;
            end else begin
              fcnt_nxt[i] = fcnt[i] + CW'(1);
            end
          end else begin
            fcnt_nxt[i] = '0;
          end
        end
        // Gray-code step: up when prev[a] differs from new b
        if (en && (filt != prev)) begin
          if (&(filt ^ prev)) begin
            err_nxt = 1'b1;
            if (!(&err_cnt)) begin
              err_cnt_nxt = err_cnt + ERRW'(1);
            end
          end else begin
            step_nxt = 1'b1;
            dir_nxt  = ~(prev[1] ^ filt[0]);
          end
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  assign ab_q = filt;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: stimulus queues expected step/err
// events, a negedge monitor pops and compares whatever the DUT emits.
module tb_quad_step_decoder;

  localparam int unsigned FILT = 3;
  localparam int unsigned ERRW = 2;
  localparam int unsigned LAT  = FILT + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            a, b, en;
  logic            step, dir, err;
  logic [ERRW-1:0] err_cnt;
  logic [1:0]      ab_q;

  quad_step_decoder #(.FILT(FILT), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en),
    .step(step), .dir(dir), .err(err), .err_cnt(err_cnt), .ab_q(ab_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit is_err;
    bit dir;
    int ecnt;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [1:0] model_ab;
  bit         model_dir;
  int         model_ecnt;
  logic [3:0] cnt4 = 4'd0;
  bit         cnt_clr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // External 4-bit counter using dir as its mode input
  always @(posedge clk) begin
    if (cnt_clr) cnt4 <= 4'd0;
    else if (step) cnt4 <= dir ? cnt4 - 4'd1 : cnt4 + 4'd1;
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the queue, late heads are misses
  always @(negedge clk) begin
    if (rst) begin
      if (step || err) begin
        if (q.size() == 0) begin
          check("unexpected_event", int'({step, err}), 0);
        end else begin
          ev_t e;
          e = q.pop_front();
          check("ev_kind", int'({step, err}), e.is_err ? 1 : 2);
          check("ev_cycle", cyc, e.cyc);
          check("ev_dir", int'(dir), int'(e.dir));
          if (e.is_err) check("ev_err_cnt", int'(err_cnt), e.ecnt);
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        check("missed_event", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  // Drive a new {a,b}, queue the expected response, hold for n cycles
  task automatic go(input logic [1:0] v, input int n);
    ev_t e;
    @(negedge clk);
    if (v != model_ab) begin
      if (en) begin
        e.cyc = cyc + LAT;
        if ((v ^ model_ab) == 2'b11) begin
          if (model_ecnt < 3) model_ecnt++;
          e.is_err = 1'b1;
        end else begin
          model_dir = !(model_ab[1] ^ v[0]);
          e.is_err = 1'b0;
        end
        e.dir  = model_dir;
        e.ecnt = model_ecnt;
        q.push_back(e);
      end
      model_ab = v;
    end
    {a, b} = v;
    repeat (n) @(posedge clk);
  endtask

  // Drive without touching the model (glitches, reset interruption)
  task automatic go_raw(input logic [1:0] v, input int n);
    @(negedge clk);
    {a, b} = v;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst = 1'b0;
    a = 1'b1;
    b = 1'b1;
    en = 1'b1;
    model_ab = 2'b11;
    model_dir = 1'b0;
    model_ecnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_step", int'(step), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_ab_q", int'(ab_q), 0);
    rst = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check("init_ab_q", int'(ab_q), 3);
    check("init_err_cnt", int'(err_cnt), 0);

    // walk to 00 legally, then clear the external counter
    go(2'b10, 10);
    go(2'b00, 10);
    @(negedge clk) cnt_clr = 1'b1;
    @(negedge clk) cnt_clr = 1'b0;

    go(2'b01, 10); go(2'b11, 10); go(2'b10, 10); go(2'b00, 10);
    check("cnt_forward", int'(cnt4), 4);
    go(2'b10, 10); go(2'b11, 10); go(2'b01, 10); go(2'b00, 10);
    check("cnt_reverse", int'(cnt4), 0);
    go(2'b10, 10); go(2'b11, 10);
    check("cnt_wrap", int'(cnt4), 14);

    // 2-cycle glitch is filtered, 3-cycle pulse is accepted
    go_raw(2'b01, 2);
    go_raw(2'b11, 10);
    check("glitch_ab_q", int'(ab_q), 3);
    go(2'b01, 3);
    go(2'b11, 10);

    // double-bit transitions saturate the 2-bit error counter
    go(2'b00, 10); go(2'b11, 10); go(2'b00, 10); go(2'b11, 10); go(2'b00, 10);
    check("err_cnt_sat", int'(err_cnt), 3);

    // disabled decode: no events now, no catch-up later
    @(negedge clk) en = 1'b0;
    go(2'b01, 10); go(2'b11, 10);
    @(negedge clk) en = 1'b1;
    repeat (10) @(posedge clk);
    go(2'b10, 10);
    check("en_ab_q", int'(ab_q), 2);

    // asynchronous reset in the middle of a pending transition
    go_raw(2'b00, 2);
    #2 rst = 1'b0;
    #1;
    check("midrst_step", int'(step), 0);
    check("midrst_dir", int'(dir), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_err_cnt", int'(err_cnt), 0);
    check("midrst_ab_q", int'(ab_q), 0);
    model_ab = 2'b00;
    model_dir = 1'b0;
    model_ecnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check("rerun_ab_q", int'(ab_q), 0);
    check("rerun_err_cnt", int'(err_cnt), 0);
    go(2'b01, 10);

    repeat (20) @(posedge clk);
    @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
